spi_flash_resp: RTL and testbench

SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

---
 rtl/spi_flash_resp.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_flash_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_resp.sv
// SPI mode-0 read-only flash responder: decodes a READ opcode plus address,
// fetches 32-bit words from a backing store and streams them MSB first until ss_n rises.
module spi_flash_resp #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         ADDR_W   = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              cmd_err,
  output logic              busy
);

  localparam int BITS_MAX = (ADDR_W > 32) ? ADDR_W : 32;
  localparam int CNT_W    = $clog2(BITS_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_FETCH  = 3'd3,
    S_DATA   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  logic [2:0]        sck_sync_q;
  logic [1:0]        ss_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              sck_rise_s;
  logic              sck_fall_s;
  logic              ss_n_s;
  logic              mosi_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        cmd_sh_q, cmd_sh_d;
  logic [ADDR_W-2:0] addr_sh_q, addr_sh_d;
  logic [31:0]       data_sh_q, data_sh_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              miso_q, miso_d;
  logic              cmd_err_q, cmd_err_d;
  logic              busy_q, busy_d;
  logic [1:0]        settle_q;
  logic              armed_q;
  logic [7:0]        opcode_s;
  logic [ADDR_W-1:0] addr_full_s;

  // Synchronize the asynchronous SPI pins; a third sck flop provides edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= 3'b000;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
      ss_sync_q   <= {ss_sync_q[0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  assign sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s  = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_n_s      = ss_sync_q[1];
  assign mosi_s      = mosi_sync_q[1];
  assign opcode_s    = {cmd_sh_q, mosi_s};
  assign addr_full_s = {addr_sh_q, mosi_s};

  // Arm only after the synchronizer has settled and ss_n was seen high, so a select
  // held low across reset is not taken as a new transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end else if (ss_n_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_sh_q   <= 7'd0;
      addr_sh_q  <= '0;
      data_sh_q  <= 32'd0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      miso_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_sh_q   <= cmd_sh_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      miso_q     <= miso_d;
      cmd_err_q  <= cmd_err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; a deselect outranks any sck edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_sh_d   = cmd_sh_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    miso_d     = miso_q;
    cmd_err_d  = 1'b0;

    if (ss_n_s && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      mem_req_d = 1'b0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d     = '0;
          mem_req_d = 1'b0;
          miso_d    = 1'b0;
          if (armed_q && !ss_n_s) begin
            state_d = S_CMD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (sck_rise_s) begin
            cmd_sh_d = opcode_s[6:0];
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              if (opcode_s == READ_CMD) begin
                state_d = S_ADDR;
              end else begin
                state_d   = S_IGNORE;
                cmd_err_d = 1'b1;
              end
            end else begin
              state_d = S_CMD;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_ADDR: begin
          miso_d = 1'b0;
          if (sck_rise_s) begin
            addr_sh_d = addr_full_s[ADDR_W-2:0];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d      = '0;
              mem_addr_d = addr_full_s;
              mem_req_d  = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_ADDR;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_FETCH: begin
          // An sck fall here has no word to shift out yet, so it drives 0 and is not counted.
          if (sck_fall_s) begin
            miso_d = 1'b0;
          end else begin
            miso_d = miso_q;
          end
          if (mem_ack) begin
            mem_req_d = 1'b0;
            data_sh_d = mem_rdata;
            cnt_d     = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DATA: begin
          if (sck_fall_s) begin
            miso_d    = data_sh_q[31];
            data_sh_d = {data_sh_q[30:0], 1'b0};
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(31)) begin
              cnt_d      = '0;
              mem_addr_d = mem_addr_q + ADDR_W'(4);
              mem_req_d  = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_IGNORE: begin
          miso_d  = 1'b0;
          state_d = S_IGNORE;
        end
        default: begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          mem_req_d = 1'b0;
          miso_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign spi_miso = miso_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: a bit-banged SPI master and a randomized-latency memory,
// with expected words/addresses derived from the read protocol itself.
module tb_spi_flash_resp;

  localparam int HALF = 12;

  logic        clock;
  logic        reset;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cmd_err;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cmd_err_cnt = 0;
  bit          resp_en = 1'b1;
  logic [31:0] salt;
  logic [23:0] fetch_q[$];
  logic [31:0] rx_words[$];
  logic        hdr_miso;

  spi_flash_resp #(.READ_CMD(8'h03), .ADDR_W(24)) dut (
    .clock     (clock),
    .reset     (reset),
    .spi_sck   (spi_sck),
    .spi_ss_n  (spi_ss_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Backing-store contents: two fixed words, everything else a salted address hash.
  function automatic logic [31:0] word_of(input logic [23:0] a);
    if (a == 24'h000010) return 32'hDEADBEEF;
    if (a == 24'h000014) return 32'h12345678;
    return ({8'h00, a} * 32'h9E3779B1) ^ salt;
  endfunction

  // Memory: answers each request after 1..4 cycles, checking address stability and req drop.
  initial begin
    logic [23:0] a;
    int          lat;
    bit          dropped;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (mem_req && resp_en && !reset) begin
        a = mem_addr;
        fetch_q.push_back(a);
        lat = $urandom_range(1, 4);
        dropped = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(negedge clock);
          if (!mem_req) begin
            dropped = 1'b1;
            break;
          end
          check_eq("fetch_addr_stable", {8'h00, mem_addr}, {8'h00, a});
        end
        if (!dropped) begin
          mem_ack   = 1'b1;
          mem_rdata = word_of(a);
          @(negedge clock);
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
          check_eq("req_drop_after_ack", {31'd0, mem_req}, 32'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmd_err) cmd_err_cnt++;
    end
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HALF) @(negedge clock);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] op, input logic [23:0] addr,
                           input int hdr_bits, input int nwords);
    logic [31:0] hdr;
    logic [31:0] w;
    logic        m;
    hdr = {op, addr};
    hdr_miso = 1'b0;
    rx_words.delete();
    spi_ss_n = 1'b0;
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < hdr_bits; i++) begin
      spi_bit(hdr[31-i], m);
      hdr_miso = hdr_miso | m;
    end
    for (int k = 0; k < nwords; k++) begin
      w = 32'h0;
      for (int i = 0; i < 32; i++) begin
        spi_bit(1'($urandom_range(0, 1)), m);
        w = {w[30:0], m};
      end
      rx_words.push_back(w);
    end
  endtask

  task automatic spi_end();
    repeat (2 * HALF) @(negedge clock);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  // Continuous read: word k comes from addr+4k (mod 2^24); one extra prefetch follows the last word.
  task automatic check_read(input string tag, input logic [23:0] addr, input int nwords);
    logic [23:0] ea;
    check_eq({tag, "_hdr_miso"}, {31'd0, hdr_miso}, 32'd0);
    check_eq({tag, "_nfetch"}, fetch_q.size(), nwords + 1);
    check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    for (int k = 0; k < nwords + 1; k++) begin
      ea = addr + 24'(4 * k);
      if (k < fetch_q.size()) check_eq({tag, "_fetch_addr"}, {8'h00, fetch_q[k]}, {8'h00, ea});
      if (k < nwords) check_eq({tag, "_word"}, rx_words[k], word_of(ea));
    end
  endtask

  task automatic do_read(input string tag, input logic [23:0] addr, input int nwords);
    fetch_q.delete();
    spi_frame(8'h03, addr, 32, nwords);
    spi_end();
    check_read(tag, addr, nwords);
  endtask

  initial begin
    logic [23:0] ra;
    logic        m;
    salt     = $urandom;
    reset    = 1'b1;
    spi_sck  = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("rst_miso",    {31'd0, spi_miso}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req},  32'd0);
    check_eq("rst_mem_addr", {8'h00, mem_addr}, 32'd0);
    check_eq("rst_cmd_err", {31'd0, cmd_err},  32'd0);
    check_eq("rst_busy",    {31'd0, busy},     32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Two-word read from 0x10: DEADBEEF then 12345678 from 0x14.
    do_read("rd_0x10", 24'h000010, 2);

    // Unsupported opcode: one cmd_err pulse, no fetch, miso held low.
    fetch_q.delete();
    cmd_err_cnt = 0;
    spi_frame(8'h0B, 24'h000010, 32, 1);
    check_eq("bad_op_busy", {31'd0, busy}, 32'd1);
    spi_end();
    check_eq("bad_op_cmd_err_cycles", cmd_err_cnt, 32'd1);
    check_eq("bad_op_nfetch", fetch_q.size(), 32'd0);
    check_eq("bad_op_miso", rx_words[0], 32'd0);
    check_eq("bad_op_hdr_miso", {31'd0, hdr_miso}, 32'd0);
    check_eq("bad_op_busy_end", {31'd0, busy}, 32'd0);
    do_read("rd_after_bad", 24'h000010, 1);

    // Address wrap at the top of the space.
    do_read("rd_wrap", 24'hFFFFFC, 2);

    // Deselect after 12 address bits.
    fetch_q.delete();
    spi_frame(8'h03, 24'h123456, 20, 0);
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("abort_addr_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_addr_req", {31'd0, mem_req}, 32'd0);
    repeat (HALF) @(negedge clock);
    check_eq("abort_addr_nfetch", fetch_q.size(), 32'd0);

    // Deselect during FETCH, then a late ack that must be discarded.
    resp_en = 1'b0;
    spi_frame(8'h03, 24'h000040, 32, 0);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clock);
    check_eq("abort_fetch_req_seen", {31'd0, mem_req}, 32'd1);
    check_eq("abort_fetch_addr", {8'h00, mem_addr}, 32'h000040);
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("abort_fetch_req", {31'd0, mem_req}, 32'd0);
    check_eq("abort_fetch_busy", {31'd0, busy}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clock);
    check_eq("late_ack_busy", {31'd0, busy}, 32'd0);
    check_eq("late_ack_req", {31'd0, mem_req}, 32'd0);
    check_eq("late_ack_miso", {31'd0, spi_miso}, 32'd0);
    resp_en = 1'b1;
    repeat (HALF) @(negedge clock);
    do_read("rd_after_abort", 24'h000100, 1);

    // Reset in the middle of a data word.
    fetch_q.delete();
    spi_frame(8'h03, 24'h000010, 32, 0);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, m);
    repeat (HALF) @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_miso",    {31'd0, spi_miso}, 32'd0);
    check_eq("mid_rst_mem_req", {31'd0, mem_req},  32'd0);
    check_eq("mid_rst_mem_addr", {8'h00, mem_addr}, 32'd0);
    check_eq("mid_rst_cmd_err", {31'd0, cmd_err},  32'd0);
    check_eq("mid_rst_busy",    {31'd0, busy},     32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("held_ss_no_start", {31'd0, busy}, 32'd0);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge clock);
    do_read("rd_after_rst", 24'h000010, 2);

    // Random reads.
    for (int r = 0; r < 3; r++) begin
      ra = 24'($urandom);
      do_read("rd_rand", ra, $urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
